// File: rtl/dds_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dds_word_sequencer
// Brief   : Queues DDS control words and issues them one by one to the SPI
//           stage, skipping consecutive duplicates and pacing on spi_ready.
// Rev     : 1.0  initial release
// ============================================================================
module dds_word_sequencer #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [15:0]              wr_data,
    input  logic                     wr_en,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic                     spi_ready,
    output logic [15:0]              out_data,
    output logic                     out_update,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     busy,
    output logic                     skipped,
    output logic                     overflow,
    output logic                     err_timeout
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_tw = $clog2(ACK_TIMEOUT + 1);
    localparam int c_gw = $clog2(GAP_CYCLES + 1);
    localparam logic [c_aw:0]   c_full_level = (c_aw + 1)'(DEPTH);
    localparam logic [c_tw-1:0] c_timer_last = c_tw'(ACK_TIMEOUT - 1);
    localparam logic [c_gw-1:0] c_gap_last   = c_gw'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t            r_state, w_next_state;
    logic [15:0]       r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]     r_level;
    logic [15:0]       r_last_word, r_out_data;
    logic              r_update, r_skipped, r_overflow, r_err_timeout;
    logic [c_tw-1:0]   r_timer, w_timer_next;
    logic [c_gw-1:0]   r_gap, w_gap_next;

    logic              w_full, w_empty, w_push, w_pop, w_issue, w_timeout, w_drop;
    logic [15:0]       w_head;

    assign w_full  = (r_level == c_full_level);
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_push  = wr_en && !w_full && !flush;
    // A write into a full FIFO is lost even if a pop frees a slot this cycle.
    assign w_drop  = wr_en && w_full && !flush;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_timeout    = 1'b0;
        w_timer_next = r_timer;
        w_gap_next   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head != r_last_word) begin
                        w_issue      = 1'b1;
                        w_next_state = S_WAIT_BUSY;
                        w_timer_next = '0;
                    end
                end
            end
            S_WAIT_BUSY: begin
                w_timer_next = r_timer + c_tw'(1);
                if (!spi_ready) begin
                    w_next_state = S_WAIT_DONE;
                end else if (r_timer == c_timer_last) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_GAP;
                    w_gap_next   = '0;
                end
            end
            S_WAIT_DONE: begin
                if (spi_ready) begin
                    w_next_state = S_GAP;
                    w_gap_next   = '0;
                end
            end
            S_GAP: begin
                w_gap_next = r_gap + c_gw'(1);
                if (r_gap == c_gap_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_gap         <= '0;
            r_last_word   <= '0;
            r_out_data    <= '0;
            r_update      <= 1'b0;
            r_skipped     <= 1'b0;
            r_overflow    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timer   <= w_timer_next;
            r_gap     <= w_gap_next;
            r_update  <= w_issue;
            r_skipped <= w_pop && !w_issue;
            if (w_issue) begin
                r_out_data  <= w_head;
                r_last_word <= w_head;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (clr_err) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    // Flush wins over both push and pop; the popped head is still consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_aw + 1)'(1);
                2'b01:   r_level <= r_level - (c_aw + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign out_data    = r_out_data;
    assign out_update  = r_update;
    assign level       = r_level;
    assign full        = w_full;
    assign empty       = w_empty;
    assign busy        = (r_state != S_IDLE);
    assign skipped     = r_skipped;
    assign overflow    = r_overflow;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dds_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_dds_word_sequencer
// Brief   : Self-checking bench for dds_word_sequencer with an SPI-stage model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dds_word_sequencer;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int GAP_CYCLES  = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic        spi_ready;
    logic [15:0] out_data;
    logic        out_update, full, empty, busy, skipped, overflow, err_timeout;
    logic [$clog2(DEPTH):0] level;

    // spi_ready comes either from the autonomous SPI model or from the test.
    logic resp_en = 1'b0, resp_ready = 1'b1, man_ready = 1'b1;
    int   frame_len = 5;
    assign spi_ready = resp_en ? resp_ready : man_ready;

    int          n_checks = 0, n_fail = 0;
    int          skip_cnt = 0;
    logic [15:0] strobe_q[$];
    logic [15:0] model_last = '0;

    dds_word_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rstn(rstn), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
        .clr_err(clr_err), .spi_ready(spi_ready), .out_data(out_data),
        .out_update(out_update), .level(level), .full(full), .empty(empty),
        .busy(busy), .skipped(skipped), .overflow(overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream stage: drops spi_ready 3 cycles after a strobe for frame_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && out_update) begin
                repeat (2) @(negedge clk);
                resp_ready = 1'b0;
                repeat (frame_len) @(negedge clk);
                resp_ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_update) strobe_q.push_back(out_data);
            if (skipped) skip_cnt++;
            if (out_update || skipped) begin
                n_checks++;
                if (out_update && skipped) begin
                    n_fail++;
                    $display("FAIL strobe_skip_exclusive: out_update=1 skipped=1, required not both");
                end
            end
        end
    end

    task automatic write_word(input logic [15:0] w);
        wr_data = w;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        resp_en = 1'b0;
        man_ready = 1'b1;
        wr_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        rstn = 1'b0;
        repeat (20) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        strobe_q.delete();
        skip_cnt = 0;
        model_last = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || !empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (busy || !empty) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%0b empty=%0b after %0d cycles, required idle", name, busy, empty, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!out_update && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!out_update) begin
            n_fail++;
            $display("FAIL %s_strobe: no out_update within 40 cycles, required a strobe", name);
        end
    endtask

    task automatic test_reset();
        logic [26:0] got, exp_v;
        resp_en = 1'b1;
        frame_len = 5;
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) write_word(16'(16'h0100 + i));
        repeat (6) @(negedge clk);
        resp_en = 1'b0;
        rstn = 1'b0;
        repeat (20) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        got   = {out_data, out_update, 4'(level), full, empty, busy, skipped, overflow, err_timeout};
        exp_v = {16'h0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset_values: got %h, required %h", got, exp_v);
        end
        strobe_q.delete();
        skip_cnt = 0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (strobe_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_update: %0d strobes, required 0", strobe_q.size());
        end
        // last_word must be back at 0, so a zero word is a duplicate.
        write_word(16'h0000);
        repeat (4) @(negedge clk);
        n_checks++;
        if (skip_cnt != 1 || strobe_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_last_word: skips=%0d strobes=%0d, required 1 and 0", skip_cnt, strobe_q.size());
        end
    endtask

    task automatic test_single_word();
        int cnt;
        do_reset();
        write_word(16'h1234);
        wait_strobe("single");
        n_checks++;
        if (out_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_data: out_data=%h, required 1234", out_data);
        end
        @(negedge clk);
        n_checks++;
        if (out_update !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse_width: out_update=%b one cycle later, required 0", out_update);
        end
        @(negedge clk);
        man_ready = 1'b0;
        repeat (34) @(negedge clk);
        man_ready = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != GAP_CYCLES) begin
            n_fail++;
            $display("FAIL single_gap: busy fell %0d cycles after spi_ready sampled high, required %0d", cnt, GAP_CYCLES);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (strobe_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: %0d strobes, required 1", strobe_q.size());
        end
    endtask

    task automatic test_duplicates();
        logic [15:0] words[$];
        logic [15:0] exp_q[$];
        int          exp_skips = 0;
        do_reset();
        resp_en = 1'b1;
        frame_len = 6;
        words = '{16'h1234, 16'h1234, 16'h0000, 16'h5678};
        foreach (words[i]) begin
            if (words[i] != model_last) begin
                exp_q.push_back(words[i]);
                model_last = words[i];
            end else begin
                exp_skips++;
            end
            write_word(words[i]);
        end
        wait_idle(300, "dup");
        n_checks++;
        if (strobe_q.size() != exp_q.size() || skip_cnt != exp_skips) begin
            n_fail++;
            $display("FAIL dup_counts: strobes=%0d skips=%0d, required %0d and %0d",
                     strobe_q.size(), skip_cnt, exp_q.size(), exp_skips);
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (strobe_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL dup_word%0d: got %h, required %h", i, strobe_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        man_ready = 1'b0;
        for (int i = 1; i <= 9; i++) write_word(16'(i));
        n_checks++;
        if (level !== 4'(DEPTH) || full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fill: level=%0d full=%b overflow=%b, required %0d 1 0", level, full, overflow, DEPTH);
        end
        write_word(16'h000A);
        n_checks++;
        if (overflow !== 1'b1 || level !== 4'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%b level=%0d, required 1 and %0d", overflow, level, DEPTH);
        end
        frame_len = 4;
        resp_ready = 1'b1;
        resp_en = 1'b1;
        wait_idle(600, "ovf");
        n_checks++;
        if (strobe_q.size() != 9) begin
            n_fail++;
            $display("FAIL ovf_count: %0d strobes, required 9", strobe_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (strobe_q[i] !== 16'(i + 1)) begin
                    n_fail++;
                    $display("FAIL ovf_order%0d: got %h, required %h", i, strobe_q[i], 16'(i + 1));
                end
            end
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        write_word(16'hABCD);
        wait_strobe("tmo");
        cnt = 0;
        while (!err_timeout && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != ACK_TIMEOUT) begin
            n_fail++;
            $display("FAIL tmo_latency: err_timeout after %0d cycles, required %0d", cnt, ACK_TIMEOUT);
        end
        repeat (GAP_CYCLES - 1) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_gap_busy: busy=%b, required 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_gap_end: busy=%b, required 0", busy);
        end
        resp_en = 1'b1;
        frame_len = 5;
        write_word(16'hBEEF);
        wait_idle(200, "tmo");
        n_checks++;
        if (strobe_q.size() != 2 || strobe_q[strobe_q.size() - 1] !== 16'hBEEF || err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_next: strobes=%0d err_timeout=%b, required 2 ending BEEF and 1",
                     strobe_q.size(), err_timeout);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: err_timeout=%b, required 0", err_timeout);
        end
    endtask

    task automatic test_flush();
        do_reset();
        write_word(16'h1111);
        wait_strobe("flush");
        repeat (2) @(negedge clk);
        man_ready = 1'b0;
        write_word(16'h0002);
        write_word(16'h0003);
        write_word(16'h0004);
        n_checks++;
        if (level !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_queued: level=%0d busy=%b, required 3 and 1", level, busy);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (level !== 4'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_level: level=%0d empty=%b, required 0 and 1", level, empty);
        end
        repeat (5) @(negedge clk);
        man_ready = 1'b1;
        wait_idle(50, "flush");
        repeat (20) @(negedge clk);
        n_checks++;
        if (strobe_q.size() != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_more: strobes=%0d busy=%b, required 1 and 0", strobe_q.size(), busy);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic [15:0] w;
        int          exp_skips = 0;
        int          n;
        do_reset();
        resp_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            frame_len = int'($urandom_range(2, 12));
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) begin
                w = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2));
                if (w != model_last) begin
                    exp_q.push_back(w);
                    model_last = w;
                end else begin
                    exp_skips++;
                end
                write_word(w);
                if ($urandom_range(0, 2) == 0) @(negedge clk);
            end
            wait_idle(800, "rand");
        end
        n_checks++;
        if (strobe_q.size() != exp_q.size() || skip_cnt != exp_skips || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_counts: strobes=%0d skips=%0d overflow=%b, required %0d %0d 0",
                     strobe_q.size(), skip_cnt, overflow, exp_q.size(), exp_skips);
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (strobe_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_word%0d: got %h, required %h", i, strobe_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_single_word();
        test_duplicates();
        test_overflow();
        test_timeout();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
